// File: rtl/pc_register_unit_pkg.sv
// Shared encodings for the PC register unit: branch types, exception codes
// and trap sequencer states.
package pc_register_unit_pkg;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LE = 2'b10;
  localparam logic [1:0] BR_GT = 2'b11;

  localparam logic [1:0] EXC_OPCODE = 2'd0;
  localparam logic [1:0] EXC_OVF    = 2'd1;
  localparam logic [1:0] EXC_DIV0   = 2'd2;
  localparam logic [1:0] EXC_ALIGN  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRAP_RD = 2'd1,
    ST_TRAP_LD = 2'd2
  } trap_state_e;

endpackage

// File: rtl/pc_branch_cond.sv
// Branch condition evaluation from ALU flags; purely combinational.
module pc_branch_cond
  import pc_register_unit_pkg::*;
(
  input  logic [1:0] branch_type,
  input  logic       alu_zero,
  input  logic       alu_gt,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (branch_type)
      BR_EQ:   cond = alu_zero;
      BR_NE:   cond = ~alu_zero;
      BR_LE:   cond = ~alu_gt;
      BR_GT:   cond = alu_gt;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_register_unit.sv
// Program counter register with EPC capture and a trap sequencer that fetches
// the handler byte from the exception table. Optional: PC_ALIGN_CHECK_EN.
module pc_register_unit
  import pc_register_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] EXC_TABLE_BASE = 32'h0000_00FD,
  parameter logic [31:0] EPC_OFFSET     = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_type,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        exc_mem_rd,
  output logic [31:0] exc_addr,
  output logic        exc_busy
);

  trap_state_e state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic [1:0]  code_q;
  logic [7:0]  hbyte_q;
  logic        cond;
  logic        we;
  logic        misalign;

  pc_branch_cond u_branch_cond (
    .branch_type (branch_type),
    .alu_zero    (alu_zero),
    .alu_gt      (alu_gt),
    .cond        (cond)
  );

  assign we = pc_write | (pc_write_cond & cond);

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = we & (pc_next[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (exc_req || misalign) state_d = ST_TRAP_RD;
      ST_TRAP_RD: if (mem_valid) state_d = ST_TRAP_LD;
      ST_TRAP_LD: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // External exceptions outrank the internal alignment trap, which outranks a commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'd0;
      code_q  <= EXC_OPCODE;
      hbyte_q <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_RUN: begin
          if (exc_req) begin
            epc_q  <= pc_q - EPC_OFFSET;
            code_q <= exc_code;
          end else if (misalign) begin
            epc_q  <= pc_q;
            code_q <= EXC_ALIGN;
          end else if (we) begin
            pc_q   <= pc_next;
          end
        end
        ST_TRAP_RD: if (mem_valid) hbyte_q <= mem_rdata;
        ST_TRAP_LD: pc_q <= {24'd0, hbyte_q};
        default: ;
      endcase
    end
  end

  // Trap outputs decode only the state register, never exc_req
  assign exc_busy   = (state_q != ST_RUN);
  assign exc_mem_rd = (state_q == ST_TRAP_RD);
  assign exc_addr   = (state_q == ST_TRAP_RD) ? (EXC_TABLE_BASE + {30'd0, code_q}) : 32'd0;
  assign pc         = pc_q;
  assign epc        = epc_q;

endmodule
